// File: rtl/urisc_loader.sv
// Boot loader for the URISC core: accepts a length-prefixed, checksummed byte image, writes it
// into RAM from address 1, clears the halt vector at 0, then hands the RAM port to the core.
module urisc_loader #(
    parameter int unsigned MEM_DEPTH      = 128,
    parameter logic [15:0] MAX_RUN_CYCLES = 16'd4096
) (
    input  logic        clk_PH1,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    input  logic        clear,
    input  logic        cpu_csmr,
    input  logic        cpu_write,
    input  logic        cpu_rdmr,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        RUN,
    output logic        mem_cs,
    output logic        mem_we,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic        halted,
    output logic        timeout,
    output logic        csum_err,
    output logic        len_err,
    output logic [15:0] run_cycles
);

    typedef enum logic [2:0] {
        StIdle, StClr0, StLoad, StCsum, StRun, StDone, StErr
    } state_e;

    localparam logic [8:0]  MaxLen    = 9'(MEM_DEPTH - 1);
    localparam logic [15:0] LastCycle = MAX_RUN_CYCLES - 16'd1;

    state_e      state_q;
    logic [7:0]  len_q;
    logic [7:0]  ptr_q;
    logic [7:0]  sum_q;
    logic [15:0] run_cycles_q;
    logic        halted_q;
    logic        timeout_q;
    logic        csum_err_q;
    logic        len_err_q;

    logic       accept;
    logic       halt_hit;
    logic [7:0] csum_total;

    // s_ready is forced low while reset is held, even though the reset state is IDLE.
    assign s_ready    = rst_n && (state_q inside {StIdle, StLoad, StCsum});
    assign accept     = s_valid && s_ready;
    assign halt_hit   = cpu_rdmr && (cpu_address == 8'h00);
    assign csum_total = sum_q + s_data;

    assign RUN         = (state_q == StRun);
    assign busy        = !(state_q inside {StIdle, StDone, StErr});
    assign done        = (state_q == StDone);
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign csum_err    = csum_err_q;
    assign len_err     = len_err_q;
    assign run_cycles  = run_cycles_q;
    assign cpu_data_in = mem_rdata;

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        case (state_q)
            StRun: begin
                mem_cs    = cpu_csmr;
                mem_we    = cpu_write;
                mem_rd    = cpu_rdmr;
                mem_addr  = cpu_address;
                mem_wdata = cpu_data_out;
            end
            StClr0: begin
                mem_cs = 1'b1;
                mem_we = 1'b1;
            end
            StLoad: begin
                mem_cs    = accept;
                mem_we    = accept;
                mem_addr  = ptr_q;
                mem_wdata = s_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_PH1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            len_q        <= 8'h00;
            ptr_q        <= 8'h00;
            sum_q        <= 8'h00;
            run_cycles_q <= 16'h0000;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            csum_err_q   <= 1'b0;
            len_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        sum_q <= s_data;
                        if ({1'b0, s_data} > MaxLen) begin
                            len_err_q <= 1'b1;
                            state_q   <= StErr;
                        end else begin
                            len_q   <= s_data;
                            ptr_q   <= 8'h01;
                            state_q <= StClr0;
                        end
                    end
                end
                StClr0: state_q <= (len_q != 8'h00) ? StLoad : StCsum;
                StLoad: begin
                    if (accept) begin
                        sum_q <= csum_total;
                        if (ptr_q == len_q) begin
                            state_q <= StCsum;
                        end else begin
                            ptr_q <= ptr_q + 8'h01;
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        if (csum_total == 8'h00) begin
                            run_cycles_q <= 16'h0000;
                            state_q      <= StRun;
                        end else begin
                            csum_err_q <= 1'b1;
                            state_q    <= StErr;
                        end
                    end
                end
                StRun: begin
                    // The terminating cycle does not count, so run_cycles holds the value seen then.
                    if (halt_hit) begin
                        halted_q <= 1'b1;
                        state_q  <= StDone;
                    end else if (run_cycles_q == LastCycle) begin
                        timeout_q <= 1'b1;
                        state_q   <= StDone;
                    end else if (run_cycles_q != 16'hFFFF) begin
                        run_cycles_q <= run_cycles_q + 16'h0001;
                    end
                end
                StDone, StErr: begin
                    if (clear) begin
                        halted_q     <= 1'b0;
                        timeout_q    <= 1'b0;
                        csum_err_q   <= 1'b0;
                        len_err_q    <= 1'b0;
                        run_cycles_q <= 16'h0000;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
